sc_canonical_engine: RTL and testbench
======================================

# sc_canonical_engine

Sequential, parametrised stochastic-computing canonical-form evaluator. Stochastic bits from the variable inputs select a minterm, and a programmable weight matrix sets each output's probability per minterm. The select bits come from an internal generator (binary counter or LFSR) instead of external inputs. The block runs for a programmed stream length and accumulates per-output ones-counts. It sits between the SC bitstream sources and the stream-to-binary readout.

## Interface
- NUM_VARS, 2: variable input bits; 2**NUM_VARS minterms per output
- NUM_CONSTS, 3: constant-generator width; weights range 0..2**NUM_CONSTS
- NUM_OUTPUTS, 2: output channels
- CNT_W, 16: width of stream length and ones-counters
- CONST_MODE, 0: 0 = binary up-counter, 1 = maximal LFSR
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  weight write strobe
- cfg_addr  in  clog2(NUM_OUTPUTS*2**NUM_VARS)  weight index k*2**NUM_VARS+v
- cfg_wdata  in  NUM_CONSTS+1  weight value
- start  in  1  begin a stream (honoured in IDLE only)
- stream_len  in  CNT_W  number of samples to consume, sampled on start
- var_inputs  in  NUM_VARS  variable bits of current sample
- var_valid  in  1  sample present; consumed in RUN
- out_bits  out  NUM_OUTPUTS  registered output bits
- out_valid  out  1  out_bits valid this cycle
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, stream complete
- counts  out  NUM_OUTPUTS*CNT_W  per-output ones-count, channel k at [k*CNT_W +: CNT_W]

## Operation
- Weights: NUM_OUTPUTS*2**NUM_VARS registers, width NUM_CONSTS+1. Written when cfg_we=1 and state is IDLE or DONE. Writes during RUN are dropped. Values >2**NUM_CONSTS are clamped to 2**NUM_CONSTS. Addresses out of range are ignored.
- Constant value c:
  - Counter mode: c counts 0..2**NUM_CONSTS-1 and wraps.
  - LFSR mode: c = state-1, with state in 1..2**NUM_CONSTS-1 and seed 1; c never equals 2**NUM_CONSTS-1.
  - Generator is reset to its seed on every accepted start.
  - Generator advances only on consumed samples.
- Output bit k for minterm v = var_inputs is (c < W[k][v]).
  - W=0 gives constant 0.
  - W=2**NUM_CONSTS gives constant 1.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: busy=0. On start, latch stream_len and clear counts. Go to RUN, or to DONE if stream_len=0.
  - RUN: each cycle with var_valid=1 consumes one sample and increments the consumed count. var_valid=0 stalls with no state change. After the stream_len-th sample is consumed, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start in RUN or DONE is ignored.
- counts hold their final values until the next accepted start or rst.
- rst at any time: state IDLE, all weights 0, generator at seed, counts 0, all outputs 0. Any in-flight stream is abandoned with no done pulse.

## Timing
- Reset values: out_bits=0, out_valid=0, busy=0, done=0, counts=0.
- Sample consumed in cycle t:
  - out_bits and out_valid=1 appear in t+1.
  - counts include that bit in t+1.
- The last sample consumed in cycle t gives out_valid=1 and done=1 in t+1, with counts final in t+1.
- busy rises the cycle after start is accepted.
- busy falls in the same cycle done rises.
- stream_len=0: done pulses 2 cycles after start, counts=0, out_valid never asserted.
- Back-to-back streams: a start in the cycle after done is accepted. Throughput is one sample per cycle.
- Counters cannot overflow because each count is ≤ stream_len < 2**CNT_W.

## Structure
- Package sc_canonical_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - CONST_MODE encodings
  - LFSR tap table function for NUM_CONSTS 2..8
- Sub-module sc_const_gen: counter or LFSR selected by CONST_MODE, with ports clk, rst, load_seed, advance, and value.
- Top contains the weight file, comparator array, FSM and counters.

## Test plan
1. Counter mode, NV=1, NC=2, NO=1, W=[1,3]. Run stream_len=4 with var=0 -> count 1, done 1 cycle after last sample. Repeat with var=1 -> count 3.
2. Weights 0 and 4 (=2**NC), stream_len=8 -> counts 0 and 8; out_bits constant.
3. LFSR mode, NC=3, W=5, stream_len=7 -> count 5. W=8, stream_len=7 -> count 7.
4. Stall: var_valid random at 50% over stream_len=8 -> same counts as the unstalled run; done only after the 8th consumed sample.
5. cfg_we and start asserted during RUN -> weights and run unaffected. stream_len=0 -> done 2 cycles after start, counts 0.
6. rst asserted mid-stream -> all outputs 0 next cycle, no done pulse. A subsequent run with all weights 0 gives counts 0.

Source files
------------

// File: rtl/sc_canonical_pkg.sv
// Shared state encoding, generator-mode encodings and LFSR tap table for the canonical engine.
// Latency: none (types and constant functions only).
// Backpressure: none.
package sc_canonical_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CONST_MODE_COUNTER = 0;
  localparam int CONST_MODE_LFSR    = 1;

  // Fibonacci tap masks (bit i = stage i+1) that give maximal-length sequences.
  function automatic logic [7:0] lfsr_taps(input int width);
    logic [7:0] taps;
    case (width)
      2:       taps = 8'h03;
      3:       taps = 8'h06;
      4:       taps = 8'h0C;
      5:       taps = 8'h14;
      6:       taps = 8'h30;
      7:       taps = 8'h60;
      8:       taps = 8'hB8;
      default: taps = 8'h00;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/sc_const_gen.sv
// Constant source for the comparators: binary up-counter or maximal LFSR (value = state-1).
// Latency: value reflects the seed the cycle after load_seed; steps one cycle after advance.
// Backpressure: holds its value whenever advance is low.
module sc_const_gen
  import sc_canonical_pkg::*;
#(
  parameter int NUM_CONSTS = 3,
  parameter int CONST_MODE = CONST_MODE_COUNTER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_seed,
  input  logic                  advance,
  output logic [NUM_CONSTS-1:0] value
);

  if (CONST_MODE == CONST_MODE_LFSR) begin : g_lfsr
    localparam logic [7:0]            TAPS = lfsr_taps(NUM_CONSTS);
    localparam logic [NUM_CONSTS-1:0] SEED = NUM_CONSTS'(1);

    logic [NUM_CONSTS-1:0] lfsr_q;
    logic                  feedback;

    assign feedback = ^(lfsr_q & TAPS[NUM_CONSTS-1:0]);

    // Shift once per consumed sample; the all-zero state is never reached.
    always_ff @(posedge clk) begin
      if (rst || load_seed) lfsr_q <= SEED;
      else if (advance)     lfsr_q <= {lfsr_q[NUM_CONSTS-2:0], feedback};
    end

    assign value = lfsr_q - SEED;
  end else begin : g_counter
    logic [NUM_CONSTS-1:0] cnt_q;

    // Free wrap through 0..2**NUM_CONSTS-1, one step per consumed sample.
    always_ff @(posedge clk) begin
      if (rst || load_seed) cnt_q <= '0;
      else if (advance)     cnt_q <= cnt_q + NUM_CONSTS'(1);
    end

    assign value = cnt_q;
  end

endmodule

// File: rtl/sc_canonical_engine.sv
// Stochastic canonical-form evaluator: minterm-selected weight vs. generated constant, per-output ones-counts.
// Latency: a sample consumed in cycle t shows on out_bits/out_valid/counts in t+1; done follows the last one by 1.
// Backpressure: var_valid low stalls the stream with no state change; start is ignored unless IDLE.
module sc_canonical_engine
  import sc_canonical_pkg::*;
#(
  parameter int NUM_VARS    = 2,
  parameter int NUM_CONSTS  = 3,
  parameter int NUM_OUTPUTS = 2,
  parameter int CNT_W       = 16,
  parameter int CONST_MODE  = CONST_MODE_COUNTER
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_we,
  input  logic [$clog2(NUM_OUTPUTS*(2**NUM_VARS))-1:0]  cfg_addr,
  input  logic [NUM_CONSTS:0]                           cfg_wdata,
  input  logic                                          start,
  input  logic [CNT_W-1:0]                              stream_len,
  input  logic [NUM_VARS-1:0]                           var_inputs,
  input  logic                                          var_valid,
  output logic [NUM_OUTPUTS-1:0]                        out_bits,
  output logic                                          out_valid,
  output logic                                          busy,
  output logic                                          done,
  output logic [NUM_OUTPUTS*CNT_W-1:0]                  counts
);

  localparam int                  NUM_MT     = 2**NUM_VARS;
  localparam int                  NUM_W      = NUM_OUTPUTS*NUM_MT;
  localparam int                  AW         = $clog2(NUM_W);
  localparam logic [NUM_CONSTS:0] W_MAX      = (NUM_CONSTS+1)'(2**NUM_CONSTS);
  localparam logic [AW:0]         ADDR_LIMIT = (AW+1)'(NUM_W);

  state_t                 state_q, state_d;
  logic                   zero_len_q;
  logic [CNT_W-1:0]       remain_q;
  logic [NUM_CONSTS:0]    weights [NUM_W];
  logic [NUM_CONSTS-1:0]  const_val;
  logic [NUM_OUTPUTS-1:0] hit;
  logic                   start_ok, consume, last_sample;

  assign start_ok    = (state_q == IDLE) && start;
  assign consume     = (state_q == RUN) && var_valid;
  assign last_sample = consume && (remain_q == CNT_W'(1));

  // Weight file: writable outside RUN only, oversize values saturate to "always 1".
  always_ff @(posedge clk) begin
    if (rst) begin
      weights <= '{default: '0};
    end else if (cfg_we && (state_q != RUN) && ({1'b0, cfg_addr} < ADDR_LIMIT)) begin
      weights[cfg_addr] <= (cfg_wdata > W_MAX) ? W_MAX : cfg_wdata;
    end
  end

  sc_const_gen #(
    .NUM_CONSTS (NUM_CONSTS),
    .CONST_MODE (CONST_MODE)
  ) u_const_gen (
    .clk       (clk),
    .rst       (rst),
    .load_seed (start_ok),
    .advance   (consume),
    .value     (const_val)
  );

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_out
    logic [AW-1:0]    ridx;
    logic [CNT_W-1:0] count_q;

    assign ridx   = AW'(k*NUM_MT) + AW'(var_inputs);
    assign hit[k] = {1'b0, const_val} < weights[ridx];

    // Ones-count for this channel: cleared on accepted start, held after the stream.
    always_ff @(posedge clk) begin
      if (rst || start_ok) count_q <= '0;
      else if (consume)    count_q <= count_q + CNT_W'(hit[k]);
    end

    assign counts[k*CNT_W +: CNT_W] = count_q;
  end

  // Registered sample result; out_bits keeps the last sample between valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_bits  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= consume;
      if (consume) out_bits <= hit;
    end
  end

  // State register, samples-remaining counter and zero-length marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      remain_q   <= '0;
      zero_len_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        remain_q   <= stream_len;
        zero_len_q <= (stream_len == '0);
      end else begin
        if (consume)           remain_q   <= remain_q - CNT_W'(1);
        if (state_q == DONE)   zero_len_q <= 1'b0;
      end
    end
  end

  // Next-state and status decode.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (stream_len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_sample) state_d = DONE;
      end
      DONE: begin
        // An empty stream dwells one extra cycle here so its done pulse lands
        // two cycles after start, matching the shortest non-empty stream.
        done = !zero_len_q;
        if (!zero_len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sc_canonical_engine.sv
module tb_sc_canonical_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: counter mode, NV=1, NC=2, NO=1
  logic        we_a, start_a;
  logic [0:0]  addr_a, var_a;
  logic [2:0]  wd_a;
  logic [0:0]  ob_a;
  logic        ov_a, busy_a, done_a;
  logic [15:0] counts_a;
  // Instance B: LFSR mode, NV=2, NC=3, NO=2
  logic        we_b, start_b;
  logic [2:0]  addr_b;
  logic [3:0]  wd_b;
  logic [1:0]  var_b;
  logic [1:0]  ob_b;
  logic        ov_b, busy_b, done_b;
  logic [31:0] counts_b;
  // Shared stream inputs
  logic [15:0] stream_len;
  logic        var_valid;

  int         total = 0;
  int         bad = 0;
  logic [1:0] exp_q[$];
  int         wa[2];
  int         wb[8];
  int         lseq[7] = '{0, 1, 4, 2, 6, 5, 3};

  sc_canonical_engine #(.NUM_VARS(1), .NUM_CONSTS(2), .NUM_OUTPUTS(1), .CNT_W(16), .CONST_MODE(0)) u_cnt (
    .clk(clk), .rst(rst), .cfg_we(we_a), .cfg_addr(addr_a), .cfg_wdata(wd_a), .start(start_a),
    .stream_len(stream_len), .var_inputs(var_a), .var_valid(var_valid), .out_bits(ob_a),
    .out_valid(ov_a), .busy(busy_a), .done(done_a), .counts(counts_a));

  sc_canonical_engine #(.NUM_VARS(2), .NUM_CONSTS(3), .NUM_OUTPUTS(2), .CNT_W(16), .CONST_MODE(1)) u_lfsr (
    .clk(clk), .rst(rst), .cfg_we(we_b), .cfg_addr(addr_b), .cfg_wdata(wd_b), .start(start_b),
    .stream_len(stream_len), .var_inputs(var_b), .var_valid(var_valid), .out_bits(ob_b),
    .out_valid(ov_b), .busy(busy_b), .done(done_b), .counts(counts_b));

  task automatic write_w(input bit use_b, input int addr, input int data);
    if (use_b) begin we_b = 1'b1; addr_b = addr[2:0]; wd_b = data[3:0]; end
    else       begin we_a = 1'b1; addr_a = addr[0:0]; wd_a = data[2:0]; end
    @(posedge clk); #1;
    we_a = 1'b0; we_b = 1'b0;
    if (use_b) wb[addr] = (data > 8) ? 8 : data;
    else       wa[addr] = (data > 4) ? 4 : data;
  endtask

  task automatic run_stream(input bit use_b, input int n, input int v, input bit stall,
                            input bit disturb, output logic [31:0] got);
    int cnt0, cnt1, consumed, cycles, c;
    logic       vv_now, obs_ov, obs_done;
    logic [1:0] eb, obs_bits, exp_bits;
    logic [31:0] exp_counts;
    cnt0 = 0; cnt1 = 0; consumed = 0; cycles = 0;
    exp_q.delete();
    stream_len = n[15:0];
    var_a = v[0:0]; var_b = v[1:0];
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    total++;
    if ((use_b ? busy_b : busy_a) !== (n > 0)) begin
      bad++; $display("FAIL busy_after_start: got %b want %b", (use_b ? busy_b : busy_a), (n > 0));
    end
    got = use_b ? counts_b : {16'd0, counts_a};
    total++;
    if (got !== 32'd0) begin bad++; $display("FAIL counts_cleared: got %0h want 0", got); end
    if (n == 0) begin
      total++;
      if ((use_b ? done_b : done_a) !== 1'b0) begin bad++; $display("FAIL zero_len_done_early: got 1 want 0"); end
      @(posedge clk); #1;
      obs_done = use_b ? done_b : done_a;
      obs_ov   = use_b ? ov_b : ov_a;
      got      = use_b ? counts_b : {16'd0, counts_a};
      total++;
      if (obs_done !== 1'b1) begin bad++; $display("FAIL zero_len_done: got %b want 1", obs_done); end
      total++;
      if (got !== 32'd0 || obs_ov !== 1'b0) begin
        bad++; $display("FAIL zero_len_outputs: counts %0h valid %b want 0 0", got, obs_ov);
      end
    end else begin
      while (consumed < n && cycles < 200) begin
        we_a = 1'b0; we_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        if (disturb && cycles == 2) begin
          if (use_b) begin we_b = 1'b1; addr_b = v[2:0]; wd_b = 4'd8; start_b = 1'b1; end
          else       begin we_a = 1'b1; addr_a = v[0:0]; wd_a = 3'd4; start_a = 1'b1; end
        end
        vv_now = stall ? 1'($urandom_range(1, 0)) : 1'b1;
        var_valid = vv_now;
        if (vv_now) begin
          c = use_b ? lseq[consumed % 7] : consumed % 4;
          exp_bits[0] = use_b ? (c < wb[v]) : (c < wa[v]);
          exp_bits[1] = use_b ? (c < wb[4 + v]) : 1'b0;
          exp_q.push_back(exp_bits);
          cnt0 += int'(exp_bits[0]);
          cnt1 += int'(exp_bits[1]);
        end
        @(posedge clk); #1;
        cycles++;
        if (vv_now) consumed++;
        obs_ov = use_b ? ov_b : ov_a;
        total++;
        if (obs_ov !== vv_now) begin bad++; $display("FAIL out_valid: got %b want %b", obs_ov, vv_now); end
        if (obs_ov === 1'b1 && exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          obs_bits = use_b ? ob_b : {1'b0, ob_a};
          total++;
          if (obs_bits !== eb) begin
            bad++; $display("FAIL out_bits sample %0d: got %b want %b", consumed - 1, obs_bits, eb);
          end
        end
        obs_done = use_b ? done_b : done_a;
        total++;
        if (obs_done !== (consumed == n)) begin
          bad++; $display("FAIL done_timing: got %b want %b after %0d samples", obs_done, (consumed == n), consumed);
        end
      end
      var_valid = 1'b0; we_a = 1'b0; we_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
      if (consumed < n) begin
        total++; bad++; $display("FAIL stream_timeout: consumed %0d want %0d", consumed, n);
      end
      exp_counts = use_b ? {cnt1[15:0], cnt0[15:0]} : {16'd0, cnt0[15:0]};
      got = use_b ? counts_b : {16'd0, counts_a};
      total++;
      if (got !== exp_counts) begin bad++; $display("FAIL counts: got %0h want %0h", got, exp_counts); end
      total++;
      if ((use_b ? busy_b : busy_a) !== 1'b0) begin bad++; $display("FAIL busy_at_done: got 1 want 0"); end
    end
    @(posedge clk); #1;
    total++;
    if ((use_b ? done_b : done_a) !== 1'b0) begin bad++; $display("FAIL done_width: got 1 want 0"); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if ({ob_a, ov_a, busy_a, done_a} !== 4'b0) begin bad++; $display("FAIL reset_a_status: got %b want 0", {ob_a, ov_a, busy_a, done_a}); end
    total++;
    if (counts_a !== 16'd0) begin bad++; $display("FAIL reset_a_counts: got %0h want 0", counts_a); end
    total++;
    if ({ob_b, ov_b, busy_b, done_b} !== 5'b0) begin bad++; $display("FAIL reset_b_status: got %b want 0", {ob_b, ov_b, busy_b, done_b}); end
    total++;
    if (counts_b !== 32'd0) begin bad++; $display("FAIL reset_b_counts: got %0h want 0", counts_b); end
    rst = 1'b0;
    wa = '{default: 0};
    wb = '{default: 0};
  endtask

  task automatic test_counter();
    logic [31:0] got;
    write_w(0, 0, 1);
    write_w(0, 1, 3);
    run_stream(0, 4, 0, 0, 0, got);
    total++;
    if (got !== 32'd1) begin bad++; $display("FAIL counter_w1: got %0d want 1", got); end
    run_stream(0, 4, 1, 0, 0, got);
    total++;
    if (got !== 32'd3) begin bad++; $display("FAIL counter_w3: got %0d want 3", got); end
  endtask

  task automatic test_extremes();
    logic [31:0] got;
    write_w(0, 0, 0);
    write_w(0, 1, 4);
    run_stream(0, 8, 0, 0, 0, got);
    total++;
    if (got !== 32'd0) begin bad++; $display("FAIL weight_zero: got %0d want 0", got); end
    run_stream(0, 8, 1, 0, 0, got);
    total++;
    if (got !== 32'd8) begin bad++; $display("FAIL weight_full: got %0d want 8", got); end
  endtask

  task automatic test_lfsr();
    logic [31:0] got;
    write_w(1, 0, 5);
    write_w(1, 4, 8);
    run_stream(1, 7, 0, 0, 0, got);
    total++;
    if (got !== {16'd7, 16'd5}) begin bad++; $display("FAIL lfsr_w5_w8: got %0h want 70005", got); end
    write_w(1, 2, 3);
    run_stream(1, 7, 2, 0, 0, got);
    total++;
    if (got !== {16'd0, 16'd3}) begin bad++; $display("FAIL lfsr_w3_w0: got %0h want 3", got); end
  endtask

  task automatic test_stall();
    logic [31:0] g1, g2;
    write_w(0, 0, 2);
    run_stream(0, 8, 0, 0, 0, g1);
    run_stream(0, 8, 0, 1, 0, g2);
    total++;
    if (g1 !== 32'd4 || g2 !== g1) begin bad++; $display("FAIL stall_counts: got %0d/%0d want 4/4", g1, g2); end
  endtask

  task automatic test_run_writes();
    logic [31:0] got;
    run_stream(0, 8, 0, 0, 1, got);
    total++;
    if (got !== 32'd4) begin bad++; $display("FAIL run_disturb: got %0d want 4", got); end
    run_stream(0, 8, 0, 0, 0, got);
    total++;
    if (got !== 32'd4) begin bad++; $display("FAIL weight_kept: got %0d want 4", got); end
    run_stream(0, 0, 0, 0, 0, got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] g1, g2;
    run_stream(1, 7, 0, 0, 0, g1);
    run_stream(1, 7, 0, 0, 0, g2);
    total++;
    if (g1 !== {16'd7, 16'd5} || g2 !== g1) begin bad++; $display("FAIL back_to_back: got %0h/%0h want 70005", g1, g2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    stream_len = 16'd8; var_b = 2'd0; var_valid = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; var_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (counts_b === 32'd0) begin bad++; $display("FAIL mid_counts_pre: got 0 want nonzero"); end
    var_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ob_b, ov_b, busy_b, done_b} !== 5'b0 || counts_b !== 32'd0) begin
      bad++; $display("FAIL mid_reset: status %b counts %0h want 0 0", {ob_b, ov_b, busy_b, done_b}, counts_b);
    end
    rst = 1'b0;
    wa = '{default: 0};
    wb = '{default: 0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (done_b !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL mid_no_done: done %b busy %b want 0 0", done_b, busy_b); end
    end
    run_stream(1, 7, 0, 0, 0, got);
    total++;
    if (got !== 32'd0) begin bad++; $display("FAIL post_reset_b: got %0h want 0", got); end
    run_stream(0, 4, 1, 0, 0, got);
    total++;
    if (got !== 32'd0) begin bad++; $display("FAIL post_reset_a: got %0h want 0", got); end
  endtask

  initial begin
    rst = 1'b1;
    we_a = 1'b0; start_a = 1'b0; addr_a = '0; wd_a = '0; var_a = '0;
    we_b = 1'b0; start_b = 1'b0; addr_b = '0; wd_b = '0; var_b = '0;
    stream_len = '0; var_valid = 1'b0;
    test_reset();
    test_counter();
    test_extremes();
    test_lfsr();
    test_stall();
    test_run_writes();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
